// File: rtl/anc_audio_pkg.sv
// anc_audio_pkg: shared widths, FSM encoding and sample-to-duty conversion
package anc_audio_pkg;
    localparam int DATA_W   = 16;
    localparam int PWM_BITS = 10;
    localparam int MID_DUTY = 2 ** (PWM_BITS - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Top PWM_BITS bits of the sample with the sign bit flipped (offset binary)
    function automatic logic [PWM_BITS-1:0] to_duty(input logic [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2 -: PWM_BITS-1]};
    endfunction
endpackage

// File: rtl/anc_pwm_audio_out_if.sv
// anc_pwm_audio_out_if: valid/ready sample stream from the SPI receiver
interface anc_pwm_audio_out_if;
    import anc_audio_pkg::*;
    logic [DATA_W-1:0] SampleIn;
    logic              SampleValid;
    logic              SampleReady;
    modport master (output SampleIn, output SampleValid, input SampleReady);
    modport slave  (input SampleIn, input SampleValid, output SampleReady);
endinterface

// File: rtl/anc_pwm_carrier.sv
// anc_pwm_carrier: free-running PWM period counter with end-of-period strobe
module anc_pwm_carrier
    import anc_audio_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic [PWM_BITS-1:0] cnt_o,
    output logic                wrap_o
);
    logic [PWM_BITS-1:0] cnt_q;

    // Count 0..2**PWM_BITS-1 and roll over naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = &cnt_q;
endmodule

// File: rtl/anc_pwm_audio_out.sv
// anc_pwm_audio_out: sample buffer + PWM speaker drive; PWM_UNDERRUN_CNT_EN adds UnderrunCount
module anc_pwm_audio_out
    import anc_audio_pkg::*;
(
    input  logic        Clk_100M,
    input  logic        ResetSwitch,
    anc_pwm_audio_out_if.slave smp,
    output logic        AudioL,
    output logic        AudioR,
    output logic        PwmActive,
`ifdef PWM_UNDERRUN_CNT_EN
    output logic [15:0] UnderrunCount,
`endif
    output logic        Underrun
);
    logic [PWM_BITS-1:0] cnt, duty_q, duty_d, pend_duty_q, pend_duty_d;
    logic                wrap, xfer, consume;
    logic                pend_v_q, pend_v_d, audio_q, audio_d, und_q, und_d;
    state_t              state_q, state_d;

    anc_pwm_carrier u_carrier (
        .clk_i  (Clk_100M),
        .rst_ni (ResetSwitch),
        .cnt_o  (cnt),
        .wrap_o (wrap)
    );

    // Transfer only into an empty slot, so it never overlaps a consuming wrap
    assign xfer    = smp.SampleValid && !pend_v_q;
    assign consume = wrap && pend_v_q;

    // Next state: duty swaps only at the period boundary to stay glitch-free
    always_comb begin
        state_d     = consume ? RUN : state_q;
        duty_d      = consume ? pend_duty_q : duty_q;
        pend_duty_d = xfer ? to_duty(smp.SampleIn) : pend_duty_q;
        pend_v_d    = xfer ? 1'b1 : (consume ? 1'b0 : pend_v_q);
        und_d       = wrap && !pend_v_q && (state_q == RUN);
        audio_d     = (state_q == RUN) && (cnt < duty_q);
    end

    // State and output registers
    always_ff @(posedge Clk_100M or negedge ResetSwitch) begin
        if (!ResetSwitch) begin
            state_q     <= IDLE;
            duty_q      <= PWM_BITS'(MID_DUTY);
            pend_duty_q <= '0;
            pend_v_q    <= 1'b0;
            audio_q     <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            pend_duty_q <= pend_duty_d;
            pend_v_q    <= pend_v_d;
            audio_q     <= audio_d;
            und_q       <= und_d;
        end
    end

`ifdef PWM_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    // Saturating count of underrun pulses, updated with the pulse itself
    always_ff @(posedge Clk_100M or negedge ResetSwitch) begin
        if (!ResetSwitch) ucnt_q <= '0;
        else              ucnt_q <= ucnt_q + {15'd0, und_d && !(&ucnt_q)};
    end

    assign UnderrunCount = ucnt_q;
`endif

    assign smp.SampleReady = !pend_v_q;
    assign AudioL          = audio_q;
    assign AudioR          = audio_q;
    assign PwmActive       = (state_q == RUN);
    assign Underrun        = und_q;
endmodule

// File: tb/tb_anc_pwm_audio_out.sv
// tb_anc_pwm_audio_out: directed + random checks of PWM audio output against a period-level model
module tb_anc_pwm_audio_out;
    localparam int PER = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic audio_l, audio_r, pwm_active, underrun;
`ifdef PWM_UNDERRUN_CNT_EN
    logic [15:0] ucount;
`endif

    anc_pwm_audio_out_if smp();

    anc_pwm_audio_out dut (
        .Clk_100M    (clk),
        .ResetSwitch (rst_n),
        .smp         (smp),
        .AudioL      (audio_l),
        .AudioR      (audio_r),
        .PwmActive   (pwm_active),
`ifdef PWM_UNDERRUN_CNT_EN
        .UnderrunCount (ucount),
`endif
        .Underrun    (underrun)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc, hi, last_hi, und_seen, m_duty;
    bit m_run, t_xfer;
    int pq[$];

    function automatic int conv(input logic [15:0] s);
        int v;
        v = $signed(s);
        return (v >>> 6) + 512;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: model reacts to the rising edge, outputs checked on the falling edge
    task automatic tick();
        int p;
        bit ex_a, ex_u;
        p = cyc % PER;
        t_xfer = smp.SampleValid && pq.size() == 0;
        ex_a = m_run && p < m_duty;
        ex_u = p == PER - 1 && pq.size() == 0 && m_run;
        if (p == PER - 1 && pq.size() != 0) begin
            m_duty = pq.pop_front();
            m_run = 1'b1;
        end
        if (t_xfer) pq.push_back(conv(smp.SampleIn));
        @(negedge clk);
        cyc++;
        chk("audio_l", audio_l, ex_a);
        chk("audio_r", audio_r, ex_a);
        chk("underrun", underrun, ex_u);
        chk("pwm_active", pwm_active, m_run);
        chk("ready", smp.SampleReady, pq.size() == 0);
        hi = (cyc % PER == 1) ? int'(audio_l) : hi + int'(audio_l);
        if (cyc % PER == 0) last_hi = hi;
        if (underrun) und_seen++;
    endtask

    task automatic to_phase0();
        do tick(); while (cyc % PER != 0);
    endtask

    task automatic send(input logic [15:0] s, output int n);
        smp.SampleValid = 1'b1;
        smp.SampleIn = s;
        n = 0;
        do begin
            tick();
            n++;
        end while (!t_xfer && n < 4 * PER);
        if (!t_xfer) begin
            compared++;
            mismatched++;
            $error("FAIL send_timeout observed=%0d expected=%0d", n, 4 * PER);
        end
        smp.SampleValid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_audio_l", audio_l, 0);
        chk("rst_audio_r", audio_r, 0);
        chk("rst_active", pwm_active, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", smp.SampleReady, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        pq.delete();
        m_run = 1'b0;
        m_duty = 512;
        hi = 0;
        last_hi = 0;
        und_seen = 0;
    endtask

    int n;

    initial begin
        smp.SampleValid = 1'b0;
        smp.SampleIn = '0;
        @(negedge clk);
        do_reset();

        // Idle for three periods
        repeat (3) to_phase0();
        chk("idle_hi", last_hi, 0);
        chk("idle_und", und_seen, 0);
        chk("idle_active", pwm_active, 0);

        // Mid-scale sample
        send(16'h0000, n);
        to_phase0();
        to_phase0();
        chk("duty_0000", last_hi, 512);
        chk("active_run", pwm_active, 1);

        // Extremes and an odd value
        send(16'h7FFF, n);
        to_phase0();
        to_phase0();
        chk("duty_7fff", last_hi, 1023);
        send(16'h8000, n);
        to_phase0();
        to_phase0();
        chk("duty_8000", last_hi, 0);
        send(16'h01F4, n);
        to_phase0();
        to_phase0();
        chk("duty_01f4", last_hi, 519);

        // One sample then starvation
        do_reset();
        send(16'h2000, n);
        to_phase0();
        chk("und_before", und_seen, 0);
        repeat (3) to_phase0();
        chk("und_pulses", und_seen, 3);
        chk("held_duty", last_hi, 640);
`ifdef PWM_UNDERRUN_CNT_EN
        tick();
        tick();
        chk("und_count", ucount, 3);
`endif

        // Back-to-back samples with backpressure
        smp.SampleValid = 1'b1;
        smp.SampleIn = 16'h1000;
        tick();
        chk("bp_ready_low", smp.SampleReady, 0);
        send(16'hF000, n);
        chk("bp_wait", n, 1024);
        to_phase0();
        chk("duty_1000", last_hi, 576);
        to_phase0();
        chk("duty_f000", last_hi, 448);

        // Reset mid-period with a sample pending
        while (cyc % PER != 250) tick();
        send(16'h4000, n);
        while (cyc % PER != 300) tick();
        chk("pre_rst_high", audio_l, 1);
        do_reset();
        chk("post_rst_ready", smp.SampleReady, 1);
        to_phase0();
        to_phase0();
        chk("post_rst_hi", last_hi, 0);
        chk("post_rst_active", pwm_active, 0);

        // Random sparse traffic
        repeat (8 * PER) begin
            smp.SampleValid = ($urandom_range(0, 299) == 0);
            smp.SampleIn = 16'($urandom);
            tick();
        end
        smp.SampleValid = 1'b0;
        to_phase0();
        chk("rand_last_hi", last_hi, m_run ? m_duty : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
